// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
// Command-driven controller for a 4-bit universal shift register.
// It accepts HOLD / SHR / SHL / LOAD commands over a valid/ready handshake.
// It drives the register's mode selects and fill/parallel inputs for N cycles.
// Bits shifted out of the register come back on bit_out, and every command ends with a done pulse.
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the FSM state (high in
// IDLE and FIN), never on cmd_valid. The cmd_* fields are sampled only at
// that transfer edge. A producer holding cmd_valid high while cmd_ready is
// low simply waits.
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             MSB_Out,
    input  logic             LSB_Out,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] Data_In,
    output logic             MSB_In,
    output logic             LSB_In,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_SHR  = 2'd1;
    localparam logic [1:0] OP_SHL  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_remaining;
    logic             r_s1;
    logic             r_s0;
    logic [WIDTH-1:0] r_data_in;
    logic             r_msb_in;
    logic             r_lsb_in;
    logic             r_bit_valid;
    logic             r_bit_out;
    logic             r_done;
    logic             r_busy;

    logic             w_ready;
    logic             w_accept;
    logic [CNT_W-1:0] w_eff_cnt;

    // Ready in IDLE and FIN so commands can run back-to-back; LOAD always lasts one cycle.
    always_comb begin
        w_ready   = (r_state != ST_EXEC);
        w_accept  = cmd_valid & w_ready;
        w_eff_cnt = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;
    end

    // Control FSM with all register-facing and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_HOLD;
            r_remaining <= '0;
            r_s1        <= 1'b0;
            r_s0        <= 1'b0;
            r_data_in   <= '0;
            r_msb_in    <= 1'b0;
            r_lsb_in    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_bit_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (w_accept) begin
                        r_op <= cmd_op;
                        if (w_eff_cnt == '0) begin
                            // Zero-length command: finish without touching the register.
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_EXEC;
                            r_remaining <= w_eff_cnt;
                            r_busy      <= 1'b1;
                            r_s1        <= cmd_op[1];
                            r_s0        <= cmd_op[0];
                            r_data_in   <= (cmd_op == OP_LOAD) ? cmd_data : '0;
                            r_msb_in    <= (cmd_op == OP_SHR) ? cmd_fill : 1'b0;
                            r_lsb_in    <= (cmd_op == OP_SHL) ? cmd_fill : 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // The register shifts on this same edge, so the end bit seen now is the one leaving.
                    if (r_op == OP_SHR) begin
                        r_bit_out   <= LSB_Out;
                        r_bit_valid <= 1'b1;
                    end else if (r_op == OP_SHL) begin
                        r_bit_out   <= MSB_Out;
                        r_bit_valid <= 1'b1;
                    end
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state   <= ST_FIN;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_s1      <= 1'b0;
                        r_s0      <= 1'b0;
                        r_data_in <= '0;
                        r_msb_in  <= 1'b0;
                        r_lsb_in  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output wiring.
    always_comb begin
        cmd_ready = w_ready;
        s1        = r_s1;
        s0        = r_s0;
        Data_In   = r_data_in;
        MSB_In    = r_msb_in;
        LSB_In    = r_lsb_in;
        bit_valid = r_bit_valid;
        bit_out   = r_bit_out;
        done      = r_done;
        busy      = r_busy;
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: the DUT drives a behavioural 4-bit universal shift register.
// A reference register tracks the expected contents and produces the expected shifted-out bits.
module tb_usr_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_count;
    logic       cmd_fill;
    logic       MSB_Out;
    logic       LSB_Out;
    logic       s1;
    logic       s0;
    logic [3:0] Data_In;
    logic       MSB_In;
    logic       LSB_In;
    logic       bit_valid;
    logic       bit_out;
    logic       done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [0:0] exp_q[$];
    logic [3:0] sw_reg;
    logic [3:0] q;
    logic [1:0] exp_mode;
    logic [3:0] exp_din;
    logic       exp_msb;
    logic       exp_lsb;
    logic       mon_en;
    int         busy_cycles;
    int         done_cnt;

    usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
        .MSB_Out(MSB_Out), .LSB_Out(LSB_Out),
        .s1(s1), .s0(s0), .Data_In(Data_In), .MSB_In(MSB_In), .LSB_In(LSB_In),
        .bit_valid(bit_valid), .bit_out(bit_out), .done(done), .busy(busy)
    );

    // Clock and downstream universal shift register.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) q <= 4'b0000;
        else begin
            case ({s1, s0})
                2'b01: q <= {MSB_In, q[3:1]};
                2'b10: q <= {q[2:0], LSB_In};
                2'b11: q <= Data_In;
                default: q <= q;
            endcase
        end
    end
    assign MSB_Out = q[3];
    assign LSB_Out = q[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard for returned bits plus per-cycle register-facing output checks.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) check("unexpected_bit_valid", 32'(bit_valid), 32'd0);
                else check("bit_out", 32'(bit_out), 32'(exp_q.pop_front()));
            end
            if (busy) begin
                busy_cycles++;
                check("s1s0", 32'({s1, s0}), 32'(exp_mode));
                check("Data_In", 32'(Data_In), 32'(exp_din));
                check("MSB_In", 32'(MSB_In), 32'(exp_msb));
                check("LSB_In", 32'(LSB_In), 32'(exp_lsb));
            end else begin
                check("idle_s1s0", 32'({s1, s0}), 32'd0);
            end
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    // Reference model of one command: sets expected drive values and queues expected bits.
    task automatic model_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                             input logic fill);
        int eff;
        eff = (op == 2'd3) ? 1 : int'(cnt);
        exp_mode = op;
        exp_din  = (op == 2'd3) ? data : 4'd0;
        exp_msb  = (op == 2'd1) ? fill : 1'b0;
        exp_lsb  = (op == 2'd2) ? fill : 1'b0;
        if (op == 2'd3) sw_reg = data;
        else if (op == 2'd1) begin
            for (int i = 0; i < eff; i++) begin
                exp_q.push_back(sw_reg[0]);
                sw_reg = {fill, sw_reg[3:1]};
            end
        end else if (op == 2'd2) begin
            for (int i = 0; i < eff; i++) begin
                exp_q.push_back(sw_reg[3]);
                sw_reg = {sw_reg[2:0], fill};
            end
        end
    endtask

    // Called just after the accept edge; waits (bounded) for done and checks the command outcome.
    task automatic wait_done(input int exp_lat, input int exp_busy);
        int lat;
        logic got;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        #1;
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
        check("register", 32'(q), 32'(sw_reg));
        check("bits_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                          input logic fill);
        int eff;
        int w;
        eff = (op == 2'd3) ? 1 : int'(cnt);
        model_cmd(op, data, cnt, fill);
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_op      = op;
        cmd_data    = data;
        cmd_count   = cnt;
        cmd_fill    = fill;
        cmd_valid   = 1'b1;
        busy_cycles = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 4'($urandom_range(0, 15));
        cmd_count = 3'($urandom_range(0, 7));
        cmd_fill  = 1'($urandom_range(0, 1));
        wait_done(eff + 1, (op == 2'd0 && cnt == 3'd0) ? 0 : eff);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s1s0"}, 32'({s1, s0}), 32'd0);
        check({tag, "_Data_In"}, 32'(Data_In), 32'd0);
        check({tag, "_fill"}, 32'({MSB_In, LSB_In}), 32'd0);
        check({tag, "_bit"}, 32'({bit_valid, bit_out}), 32'd0);
        check({tag, "_done_busy"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int d0;
        int lat_dummy;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0;
        cmd_count = 3'd0; cmd_fill = 1'b0; mon_en = 1'b0; sw_reg = 4'd0;
        exp_mode = 2'd0; exp_din = 4'd0; exp_msb = 1'b0; exp_lsb = 1'b0;
        busy_cycles = 0; done_cnt = 0;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // LOAD, then SHR by 4 returns 1,1,0,1.
        do_cmd(2'd3, 4'b1011, 3'd0, 1'b0);
        do_cmd(2'd1, 4'b0000, 3'd4, 1'b0);
        check("shr_clears", 32'(q), 32'd0);

        // LOAD 1001, SHL by 2 with fill 1 returns 1,0 and leaves 0111.
        do_cmd(2'd3, 4'b1001, 3'd0, 1'b0);
        do_cmd(2'd2, 4'b0000, 3'd2, 1'b1);
        check("shl_result", 32'(q), 32'b0111);

        // Back-to-back: LOAD 0110 then SHR 1 accepted in the LOAD's FIN cycle.
        model_cmd(2'd3, 4'b0110, 3'd0, 1'b0);
        @(negedge clk);
        cmd_op = 2'd3; cmd_data = 4'b0110; cmd_count = 3'd0; cmd_fill = 1'b0;
        cmd_valid = 1'b1;
        busy_cycles = 0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_exec_busy", 32'(busy), 32'd1);
        check("b2b_exec_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("b2b_fin_done", 32'(done), 32'd1);
        check("b2b_fin_ready", 32'(cmd_ready), 32'd1);
        check("b2b_loaded", 32'(q), 32'b0110);
        model_cmd(2'd1, 4'b0000, 3'd1, 1'b0);
        cmd_op = 2'd1; cmd_count = 3'd1; cmd_fill = 1'b0;
        busy_cycles = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(2, 1);
        check("b2b_result", 32'(q), 32'b0011);

        // HOLD 3 leaves the register alone; SHR 0 completes next cycle.
        do_cmd(2'd0, 4'b0000, 3'd3, 1'b0);
        do_cmd(2'd1, 4'b0000, 3'd0, 1'b1);
        check("corner_unchanged", 32'(q), 32'b0011);

        // Count above WIDTH: earlier fill bits come back out.
        do_cmd(2'd3, 4'($urandom_range(0, 15)), 3'd0, 1'b0);
        do_cmd(2'd2, 4'b0000, 3'd6, 1'b1);
        do_cmd(2'd1, 4'b0000, 3'd7, 1'b0);

        // A few random commands.
        for (int i = 0; i < 6; i++) begin
            do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an SHR 4: aborted, no done, everything zero.
        do_cmd(2'd3, 4'b1110, 3'd0, 1'b0);
        mon_en = 1'b0;
        @(negedge clk);
        cmd_op = 2'd1; cmd_count = 3'd4; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("mid_reset1");
        @(posedge clk);
        #1;
        check_outputs_zero("mid_reset2");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(cmd_ready), 32'd1);
        lat_dummy = 0;
        repeat (3) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt), 32'(d0));
        check("reg_cleared", 32'(q), 32'd0);
        exp_q.delete();
        sw_reg = 4'd0;
        mon_en = 1'b1;

        // Normal operation resumes after reset.
        do_cmd(2'd3, 4'b0101, 3'd0, 1'b0);
        do_cmd(2'd1, 4'b0000, 3'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
